// File: rtl/pipe_sink.sv
// Tail of the stall-carrying pipeline: buffers words in a FIFO, drives hold backpressure
// and pulses frame_done when a frame drains. Define PIPE_SINK_GROUP_CNT_EN to add group_len.
module pipe_sink #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int SKID       = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       stall_in,
    input  logic                       done_in,
    input  logic                       co_filter_in,
    output logic                       hold,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_last,
    output logic                       rd_co_filter,
    output logic                       rd_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       frame_done,
    output logic                       err
`ifdef PIPE_SINK_GROUP_CNT_EN
    ,
    output logic [15:0]                group_len
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("pipe_sink: DEPTH must be a power of two and at least 4");
    end
    if (SKID >= DEPTH) begin : g_bad_skid
        $error("pipe_sink: SKID must be less than DEPTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic                  co_filter;
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_next;
    logic            word;
    logic            open;
    logic            full;
    logic            push;
    logic            pop;

    assign word = !stall_in;
    assign open = (state == IDLE) || (state == RUN);
    assign full = (count == CW'(DEPTH));
    assign pop  = rd_en && (count != '0);
    // A full FIFO still takes a word when the same edge frees a slot.
    assign push = word && open && (!full || pop);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    // NOTE: storage is deliberately not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{co_filter: co_filter_in, last: done_in, data: data_in};
        end
    end

    assign head         = mem[rd_ptr];
    assign rd_empty     = (count == '0);
    assign rd_data      = rd_empty ? '0 : head.data;
    assign rd_last      = rd_empty ? 1'b0 : head.last;
    assign rd_co_filter = rd_empty ? 1'b0 : head.co_filter;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            hold       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            count      <= count_next;
            hold       <= (count >= CW'(DEPTH - SKID));
            err        <= err | (word && !push);
            frame_done <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case (state)
                IDLE: begin
                    if (push) begin
                        state <= done_in ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (push && done_in) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_next == '0) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIPE_SINK_GROUP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || (state == DONE)) begin
            group_len <= '0;
        end else if (push) begin
            if (co_filter_in) begin
                group_len <= 16'd1;
            end else if (group_len != 16'hFFFF) begin
                group_len <= group_len + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_sink.sv
// Directed bench for pipe_sink: a queue-based frame model checked every cycle,
// plus hand-computed literal expectations along the directed sequence.
module tb_pipe_sink;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int SKID  = 3;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;
    localparam int S_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          stall_in;
    logic          done_in;
    logic          co_filter_in;
    logic          hold;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          rd_co_filter;
    logic          rd_empty;
    logic [CW-1:0] count;
    logic          frame_done;
    logic          err;
`ifdef PIPE_SINK_GROUP_CNT_EN
    logic [15:0]   group_len;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    pipe_sink #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .stall_in     (stall_in),
        .done_in      (done_in),
        .co_filter_in (co_filter_in),
        .hold         (hold),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .rd_co_filter (rd_co_filter),
        .rd_empty     (rd_empty),
        .count        (count),
        .frame_done   (frame_done),
        .err          (err)
`ifdef PIPE_SINK_GROUP_CNT_EN
        ,
        .group_len    (group_len)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a queue of {co_filter, last, data} words plus the frame phase.
    logic [DW+1:0] m_q[$];
    int            m_state;
    bit            m_hold;
    bit            m_fd;
    bit            m_err;
    int            m_glen;

    always @(posedge clk) begin
        int  occ;
        bit  take;
        bit  give;
        if (rst) begin
            m_q.delete();
            m_state = S_IDLE;
            m_hold  = 1'b0;
            m_fd    = 1'b0;
            m_err   = 1'b0;
            m_glen  = 0;
        end else begin
            occ  = m_q.size();
            give = rd_en && (occ > 0);
            take = !stall_in && (m_state == S_IDLE || m_state == S_RUN) && (occ < DEPTH || give);
            if (!stall_in && !take) m_err = 1'b1;
            m_hold = (occ >= DEPTH - SKID);
            if (give) void'(m_q.pop_front());
            if (take) m_q.push_back({co_filter_in, done_in, data_in});
            if (m_state == S_DONE) m_glen = 0;
            else if (take) m_glen = co_filter_in ? 1 : ((m_glen < 65535) ? m_glen + 1 : 65535);
            m_fd = 1'b0;
            case (m_state)
                S_IDLE:  if (take) m_state = done_in ? S_DRAIN : S_RUN;
                S_RUN:   if (take && done_in) m_state = S_DRAIN;
                S_DRAIN: if (m_q.size() == 0) begin m_state = S_DONE; m_fd = 1'b1; end
                default: m_state = S_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [DW+1:0] h;
        if (chk_en) begin
            h = (m_q.size() > 0) ? m_q[0] : '0;
            check("count", 32'(count), 32'(m_q.size()));
            check("rd_empty", 32'(rd_empty), 32'(m_q.size() == 0));
            check("rd_data", 32'(rd_data), 32'(h[DW-1:0]));
            check("rd_last", 32'(rd_last), 32'(h[DW]));
            check("rd_co_filter", 32'(rd_co_filter), 32'(h[DW+1]));
            check("hold", 32'(hold), 32'(m_hold));
            check("frame_done", 32'(frame_done), 32'(m_fd));
            check("err", 32'(err), 32'(m_err));
`ifdef PIPE_SINK_GROUP_CNT_EN
            check("group_len", 32'(group_len), 32'(m_glen));
`endif
        end
    end

    task automatic step(input logic st, input logic [DW-1:0] d, input logic dn,
                        input logic co, input logic re);
        stall_in = st; data_in = d; done_in = dn; co_filter_in = co; rd_en = re;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [DW-1:0] d, input logic dn);
        step(1'b0, d, dn, 1'b0, 1'b0);
    endtask

    task automatic pop_expect(input string name, input logic [DW-1:0] d, input logic last);
        check(name, 32'(rd_data), 32'(d));
        check({name, "_last"}, 32'(rd_last), 32'(last));
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] order [8];
        rst = 1'b1;
        stall_in = 1'b1; data_in = '0; done_in = 1'b0; co_filter_in = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(rd_empty), 32'd1);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_err_hold", 32'({err, hold, frame_done}), 32'd0);
        rst = 1'b0;
        idle();

        // Basic frame: three words, done on the last, then drain.
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b1);
        check("t1_count", 32'(count), 32'd3);
        check("t1_model_drain", 32'(m_state), 32'(S_DRAIN));
        pop_expect("t1_pop0", 8'h11, 1'b0);
        pop_expect("t1_pop1", 8'h22, 1'b0);
        pop_expect("t1_pop2", 8'h33, 1'b1);
        check("t1_frame_done", 32'(frame_done), 32'd1);
        check("t1_empty", 32'(rd_empty), 32'd1);
        idle();
        check("t1_frame_done_clear", 32'(frame_done), 32'd0);

        // Bubbles between words are never stored.
        push(8'hA0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        push(8'hA1, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        push(8'hA2, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        push(8'hA3, 1'b1);
        check("t2_count", 32'(count), 32'd4);
        pop_expect("t2_pop0", 8'hA0, 1'b0);
        pop_expect("t2_pop1", 8'hA1, 1'b0);
        pop_expect("t2_pop2", 8'hA2, 1'b0);
        pop_expect("t2_pop3", 8'hA3, 1'b1);
        check("t2_frame_done", 32'(frame_done), 32'd1);
        idle();

        // Hold threshold at DEPTH-SKID = 5, one cycle behind the count.
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i), 1'b0);
        check("t3_count5", 32'(count), 32'd5);
        check("t3_hold_lag", 32'(hold), 32'd0);
        idle();
        check("t3_hold_set", 32'(hold), 32'd1);
        pop_expect("t3_pop", 8'h50, 1'b0);
        check("t3_count4", 32'(count), 32'd4);
        check("t3_hold_still", 32'(hold), 32'd1);
        idle();
        check("t3_hold_clear", 32'(hold), 32'd0);

        // Fill to 8, overflow drop, then push+pop at full.
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i), 1'b0);
        check("t4_full", 32'(count), 32'd8);
        check("t4_err_before", 32'(err), 32'd0);
        push(8'h99, 1'b0);
        check("t4_overflow_count", 32'(count), 32'd8);
        check("t4_overflow_err", 32'(err), 32'd1);
        step(1'b0, 8'h70, 1'b1, 1'b0, 1'b1);
        check("t4_pushpop_count", 32'(count), 32'd8);
        order = '{8'h52, 8'h53, 8'h54, 8'h60, 8'h61, 8'h62, 8'h63, 8'h70};
        for (int i = 0; i < 8; i++) pop_expect($sformatf("t4_order%0d", i), order[i], (i == 7));
        check("t4_frame_done", 32'(frame_done), 32'd1);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check("t4_rst_err", 32'(err), 32'd0);

        // A word arriving during DRAIN is dropped and flagged.
        push(8'h41, 1'b0);
        push(8'h42, 1'b1);
        push(8'h55, 1'b0);
        check("t5_drain_count", 32'(count), 32'd2);
        check("t5_drain_err", 32'(err), 32'd1);
        pop_expect("t5_pop0", 8'h41, 1'b0);
        pop_expect("t5_pop1", 8'h42, 1'b1);
        check("t5_frame_done", 32'(frame_done), 32'd1);
        idle();

        // Reset mid-frame with four words buffered.
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), 1'b0);
        check("t6_count4", 32'(count), 32'd4);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_empty", 32'(rd_empty), 32'd1);
        check("t6_rst_err", 32'(err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("t6_no_frame_done", 32'(frame_done), 32'd0);
        end

`ifdef PIPE_SINK_GROUP_CNT_EN
        begin
            logic       tags [5];
            logic [3:0] lens [5];
            tags = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
            lens = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2};
            for (int i = 0; i < 5; i++) begin
                step(1'b0, 8'hD0 + 8'(i), 1'b0, tags[i], 1'b0);
                check($sformatf("t7_group_len%0d", i), 32'(group_len), 32'(lens[i]));
            end
        end
`endif

        idle();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
